// File: rtl/debounce_multi.sv
// debounce_multi: N-channel parametrised debouncer with registered edge strobes.
//
// Each channel has three stages:
//   - a 2-FF synchroniser on its raw input;
//   - a stability counter that accepts a new level after DEBOUNCE_CYC
//     consecutive cycles that differ from the current stable level;
//   - registered rise/fall strobes, raised in the same cycle that clean_out changes.
//
// Optional feature (macro LONG_PRESS_EN):
//   - adds a per-channel hold counter;
//   - long_pulse strobes once, LONG_CYC cycles after a rise, while the level stays high;
//   - without the macro, long_pulse is tied to 0.
//
// Parameters:
//   N_CH          number of independent channels (>=1)
//   DEBOUNCE_CYC  consecutive differing cycles needed to accept a new level (>=2)
//   INIT_VAL      reset level of every channel
//   LONG_CYC      stable-high cycles after a rise before long_pulse fires (>=1)
//
// Ports:
//   clk         clock, all logic on posedge
//   rst_n       asynchronous active-low reset
//   noisy_in    raw asynchronous inputs
//   clean_out   debounced levels
//   rise_pulse  1-cycle strobe on clean_out 0->1
//   fall_pulse  1-cycle strobe on clean_out 1->0
//   long_pulse  1-cycle strobe after a long high press (LONG_PRESS_EN only)
module debounce_multi #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter logic        INIT_VAL     = 1'b0,
  parameter int unsigned LONG_CYC     = 50000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] noisy_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] long_pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  // Elaboration-time parameter sanity checks
  if (N_CH < 1) begin : g_chk_n_ch
    $error("debounce_multi: N_CH must be >= 1");
  end
  if (DEBOUNCE_CYC < 2) begin : g_chk_deb
    $error("debounce_multi: DEBOUNCE_CYC must be >= 2");
  end
  if (LONG_CYC < 1) begin : g_chk_long
    $error("debounce_multi: LONG_CYC must be >= 1");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          rise_q;
    logic          fall_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          commit_c;

    // Counter next value: zero means idle-compare, non-zero means counting
    always_comb begin
      cnt_nxt  = '0;
      commit_c = 1'b0;
      if (sync2 != stable) begin
        if (cnt == CNT_MAX) begin
          commit_c = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    end

    // Synchroniser, stable level and edge strobes
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1  <= INIT_VAL;
        sync2  <= INIT_VAL;
        stable <= INIT_VAL;
        cnt    <= '0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        sync1  <= noisy_in[i];
        sync2  <= sync1;
        cnt    <= cnt_nxt;
        rise_q <= commit_c & sync2;
        fall_q <= commit_c & ~sync2;
        if (commit_c) begin
          stable <= sync2;
        end
      end
    end

    assign clean_out[i]  = stable;
    assign rise_pulse[i] = rise_q;
    assign fall_pulse[i] = fall_q;

`ifdef LONG_PRESS_EN
    localparam int unsigned HW = $clog2(LONG_CYC + 1);

    logic [HW-1:0] hold;
    logic          long_q;

    // Hold counter saturates at LONG_CYC, so the strobe fires once per press
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold   <= '0;
        long_q <= 1'b0;
      end else begin
        long_q <= stable & (hold == HW'(LONG_CYC - 1));
        if (!stable) begin
          hold <= '0;
        end else if (hold != HW'(LONG_CYC)) begin
          hold <= hold + HW'(1);
        end
      end
    end

    assign long_pulse[i] = long_q;
`else
    assign long_pulse[i] = 1'b0;
`endif
  end

endmodule
